// File: rtl/gate1_data_mux_tdr_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// gate1_data_mux_ctrl_pkg
// Shared definitions for the gate1 data-mux IJTAG TDR controller:
//   SEL_BIT / DATA_LSB  bit positions of the select and data fields in the TDR
//   tdr_t               field view of a TDR word for the default 3-bit mux
//   cnt_width()         width of the override hold counter (never below 1)
// -----------------------------------------------------------------------------
package gate1_data_mux_ctrl_pkg;

  localparam int SEL_BIT  = 0;
  localparam int DATA_LSB = 1;
  localparam int TDR_DW   = 3;

  typedef struct packed {
    logic [TDR_DW-1:0] data;
    logic              sel;
  } tdr_t;

  // A zero hold time still needs a one-bit counter so the ports stay legal.
  function automatic int cnt_width(input int hold_cycles);
    int w;
    w = $clog2(hold_cycles + 1);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/gate1_data_mux_tdr_ctrl_if.sv
// -----------------------------------------------------------------------------
// gate1_data_mux_tdr_ctrl_if
// IJTAG scan-port bundle between the SIB/ICL network and one TDR.
//   ijtag_sel  TDR is on the active scan path
//   ijtag_ce   capture enable
//   ijtag_se   shift enable
//   ijtag_ue   update enable
//   ijtag_si   scan in
//   ijtag_so   scan out
// master: the network side (drives enables and scan in)
// slave : the TDR side (drives scan out)
// -----------------------------------------------------------------------------
interface gate1_data_mux_tdr_ctrl_if;
  logic ijtag_sel;
  logic ijtag_ce;
  logic ijtag_se;
  logic ijtag_ue;
  logic ijtag_si;
  logic ijtag_so;

  modport master (
    output ijtag_sel,
    output ijtag_ce,
    output ijtag_se,
    output ijtag_ue,
    output ijtag_si,
    input  ijtag_so
  );

  modport slave (
    input  ijtag_sel,
    input  ijtag_ce,
    input  ijtag_se,
    input  ijtag_ue,
    input  ijtag_si,
    output ijtag_so
  );
endinterface

// File: rtl/gate1_data_mux_tdr_ctrl_hold_timer.sv
// -----------------------------------------------------------------------------
// gate1_data_mux_hold_timer
// Override hold counter. Only used when GATE1_DATA_MUX_HOLD_TIMER_EN is defined.
//   clk, rst_n   test clock, asynchronous active-low reset
//   load         reload the counter with HOLD_CYCLES (wins over everything)
//   clear        force the counter to zero
//   hold_active  registered: counter is non-zero
//   expire       combinational: this edge takes the counter from 1 to 0
// -----------------------------------------------------------------------------
module gate1_data_mux_hold_timer #(
  parameter int HOLD_CYCLES = 16,
  parameter int CW          = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clear,
  output logic hold_active,
  output logic expire
);

  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] ZERO   = {CW{1'b0}};

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          hold_r;

  // Next counter value; expiry is only reported when nothing overrides the decrement.
  always_comb begin
    cnt_nxt_s = cnt_r;
    expire    = 1'b0;
    if (load) begin
      cnt_nxt_s = RELOAD;
    end else if (clear) begin
      cnt_nxt_s = ZERO;
    end else if (cnt_r != ZERO) begin
      cnt_nxt_s = cnt_r - ONE;
      expire    = (cnt_r == ONE);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Counter and registered hold flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= ZERO;
      hold_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      hold_r <= (cnt_nxt_s != ZERO);
    end
  end

  assign hold_active = hold_r;

endmodule

// File: rtl/gate1_data_mux_tdr_ctrl.sv
// -----------------------------------------------------------------------------
// gate1_data_mux_tdr_ctrl
// IJTAG test-data register controlling one gate1 DW-bit data mux.
// TDR layout (shift and update registers): bit 0 = mux select, bits DW:1 = data.
// Shifting is LSB-first, so bit 0 leaves on ijtag_so first.
//   ijtag_tck      test clock, all flops on posedge
//   ijtag_reset    asynchronous active-low reset
//   ijtag          scan port (slave side): sel/ce/se/ue/si in, so out
//   mux_data_out   mux output, sampled on capture
//   ijtag_select   mux select (1 = override data drives the mux output)
//   ijtag_data_in  override data to the mux
//   hold_active    override hold timer running
// Optional feature macro: GATE1_DATA_MUX_HOLD_TIMER_EN adds a timer that drops
// the select bit HOLD_CYCLES tck after an update that set it. Without it the
// override persists until the next update and hold_active is tied low.
// -----------------------------------------------------------------------------
module gate1_data_mux_tdr_ctrl
  import gate1_data_mux_ctrl_pkg::*;
#(
  parameter int DW          = 3,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                       ijtag_tck,
  input  logic                       ijtag_reset,
  gate1_data_mux_tdr_ctrl_if.slave   ijtag,
  input  logic [DW-1:0]              mux_data_out,
  output logic                       ijtag_select,
  output logic [DW-1:0]              ijtag_data_in,
  output logic                       hold_active
);

  logic [DW:0] sr_r;
  logic [DW:0] upd_r;
  logic        update_s;
  logic        expire_s;

  assign update_s = ijtag.ijtag_sel & ijtag.ijtag_ue;

  // Shift register: capture beats shift; capture takes the live select so a
  // timer expiry is observable through the scan chain.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      sr_r <= {(DW+1){1'b0}};
    end else if (ijtag.ijtag_sel && ijtag.ijtag_ce) begin
      sr_r <= {mux_data_out, upd_r[SEL_BIT]};
    end else if (ijtag.ijtag_sel && ijtag.ijtag_se) begin
      sr_r <= {ijtag.ijtag_si, sr_r[DW:DATA_LSB]};
    end else begin
      sr_r <= sr_r;
    end
  end

  // Update register: an update on the expiry edge wins, so select stays set.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      upd_r <= {(DW+1){1'b0}};
    end else if (update_s) begin
      upd_r <= sr_r;
    end else if (expire_s) begin
      upd_r[SEL_BIT] <= 1'b0;
    end else begin
      upd_r <= upd_r;
    end
  end

`ifdef GATE1_DATA_MUX_HOLD_TIMER_EN
  localparam int CW = cnt_width(HOLD_CYCLES);

  logic load_s;
  logic clear_s;

  // A zero hold time means the override never times out, so never load.
  assign load_s  = update_s & sr_r[SEL_BIT] & (HOLD_CYCLES > 0);
  assign clear_s = update_s & ~sr_r[SEL_BIT];

  gate1_data_mux_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .CW          (CW)
  ) u_hold_timer (
    .clk         (ijtag_tck),
    .rst_n       (ijtag_reset),
    .load        (load_s),
    .clear       (clear_s),
    .hold_active (hold_active),
    .expire      (expire_s)
  );
`else
  assign expire_s    = 1'b0;
  assign hold_active = 1'b0;
`endif

  assign ijtag.ijtag_so = sr_r[SEL_BIT];
  assign ijtag_select   = upd_r[SEL_BIT];
  assign ijtag_data_in  = upd_r[DW:DATA_LSB];

endmodule
